pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Pipelined control and hazard unit for the five-stage MIPS datapath. It decodes the instruction in ID into a control bundle and carries that bundle through internal ID/EX, EX/MEM and MEM/WB registers. It also detects load-use and jump-register hazards, drives forwarding selects, and resolves branches and jumps into PC-select and flush signals. It supersedes the single-cycle combinational controller: widths are parametrised, and forwarding can be disabled so that every RAW hazard stalls instead.

## Interface
Parameters:
- RA_W, 5, register-address width
- ALU_W, 3, ALU-op width (≥3)
- EN_FWD, 1, 1 = forwarding, 0 = stall on every RAW hazard (fwd_a/fwd_b tied 0)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_opcode  in  6  opcode of instruction in ID
- id_func  in  6  funct field in ID
- id_rs, id_rt, id_rd  in  RA_W each  register fields in ID
- ex_zero  in  1  ALU zero flag of instruction in EX
- ex_alu_op  out  ALU_W  ALU operation: add 0, sub 1, and 2, or 3, slt 4, xor 5
- ex_alu_src  out  1  1 = immediate operand
- ex_link  out  1  JAL in EX; datapath writes PC+4
- ex_illegal  out  1  undecodable instruction reached EX (executed as bubble)
- mem_read, mem_write  out  1 each  data-memory strobes
- wb_write  out  1  register-file write enable
- wb_mem_to_reg  out  1  1 = write-back from memory
- wb_dest  out  RA_W  write-back register
- fwd_a, fwd_b  out  2 each  EX operand source: 0 regfile, 1 EX/MEM, 2 MEM/WB
- stall  out  1  hold PC and IF/ID; bubble into ID/EX
- flush_ifid  out  1  squash IF/ID on next edge
- pc_sel  out  2  0 PC+4, 1 branch target, 2 jump target, 3 rs (JR)

## Operation
- Decode (ID) produces: write, dest, alu_op, alu_src, mem_read, mem_write, mem_to_reg, link, branch type, uses_rs, uses_rt.
  - R-type (opcode 0), funct ADD 32 / SUB 34 / AND 36 / OR 37 / XOR 38 / SLT 42: write=1, dest=rd, uses rs and rt.
  - JR (funct 8): no write, uses rs.
  - LW 35: add, alu_src, read, mem_to_reg, write, dest=rt.
  - SW 43: add, alu_src, mem_write, uses rs and rt.
  - ADDI 8 and SLTI 10: add or slt, alu_src, write, dest=rt.
  - BEQ 4 and BNE 5: sub, uses rs and rt.
  - J 2: no control effect. JAL 3: write, link, dest=31.
  - Any other opcode, any other R-type funct, and funct 0 (NOP): bubble. ex_illegal=1 for any undefined code, but not for NOP.
- Writes to dest 0 are suppressed: write is forced to 0.
- Load-use hazard: EX holds a LW, its dest ≠0, and dest matches id_rs (when uses_rs) or id_rt (when uses_rt). Response: stall=1 for one cycle.
- JR hazard: stall while the EX or MEM stage writes id_rs (rs ≠0).
- EN_FWD=0: stall while the EX or MEM stage writes any used source register. The register file is write-before-read, so the WB stage never causes a stall.
- Forwarding (EN_FWD=1): fwd_a=1 if EX/MEM writes, dest≠0 and dest==ex rs. Otherwise fwd_a=2 on the same test against MEM/WB. Otherwise 0. fwd_b is the same test on rt.
- Branch taken in EX: (BEQ and ex_zero) or (BNE and !ex_zero). Response: pc_sel=1, flush_ifid=1, and a bubble is loaded into ID/EX, so the ID instruction is squashed.
- Jump in ID with no stall and no taken branch: pc_sel=2 for J/JAL or 3 for JR, and flush_ifid=1. The jump itself proceeds down the pipe.
- Priority: taken branch > stall > ID jump > sequential. A taken branch cancels any simultaneous stall.

## Timing
- Instruction in ID at cycle N: ex_* valid in cycle N+1, mem_* in N+2, wb_* in N+3.
- Stage outputs come directly from registers.
- stall, flush_ifid, pc_sel and fwd_* are combinational from the stage registers, the ID inputs and ex_zero.
- Reset (async, rst_n low): all stage registers clear to a bubble, so all ex_*/mem_*/wb_* outputs are 0. stall, flush_ifid and pc_sel are forced to 0 while rst_n is low. fwd_* read 0.
- Reset mid-operation discards all in-flight control. The first instruction decoded after release reaches EX one cycle later.
- A stall never lasts more than one cycle for a load-use hazard. A JR or EN_FWD=0 stall lasts at most two cycles.

## Test plan
- ADD r3,r1,r2 then SUB r4,r3,r1 → in SUB's EX cycle fwd_a=1; ex_alu_op=1 for SUB. One cycle later (MEM/WB holds ADD) a dependent op sees fwd=2.
- LW r5 then ADD r6,r5,r5 → stall=1 for exactly one cycle, bubble enters EX, then fwd_a=fwd_b=2; with EN_FWD=0, stall for two cycles and fwd=0.
- BEQ with ex_zero=1 → pc_sel=1, flush_ifid=1; the following ID instruction never asserts wb_write. BNE with ex_zero=1 → pc_sel=0.
- JAL → pc_sel=2 and flush_ifid for one cycle; ex_link=1 and, three cycles after ID, wb_write=1 with wb_dest=31. JR r7 right after ADDI r7 → two stall cycles, then pc_sel=3.
- Opcode 63 → ex_illegal=1 and all other controls 0. ADD to r0 → wb_write=0.
- Assert rst_n low mid-stream asynchronously → all outputs 0 immediately. After release, LW decoded at N gives mem_read=1 at N+2.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control and hazard unit for a five-stage MIPS datapath: decodes ID,
// carries the control bundle through EX/MEM/WB and resolves stalls, forwarding and PC selection.
module pipe_ctrl_unit #(
    parameter int RA_W   = 5,
    parameter int ALU_W  = 3,
    parameter int EN_FWD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       id_opcode,
    input  logic [5:0]       id_func,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             ex_zero,
    output logic [ALU_W-1:0] ex_alu_op,
    output logic             ex_alu_src,
    output logic             ex_link,
    output logic             ex_illegal,
    output logic             mem_read,
    output logic             mem_write,
    output logic             wb_write,
    output logic             wb_mem_to_reg,
    output logic [RA_W-1:0]  wb_dest,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic             flush_ifid,
    output logic [1:0]       pc_sel
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_NOP = 6'd0;
    localparam logic [5:0] FN_JR  = 6'd8;
    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_XOR = 6'd38;
    localparam logic [5:0] FN_SLT = 6'd42;

    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(3'd0);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(3'd1);
    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(3'd2);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3'd3);
    localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(3'd4);
    localparam logic [ALU_W-1:0] ALU_XOR = ALU_W'(3'd5);

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;
    localparam logic [1:0] PC_JR  = 2'd3;

    localparam logic [RA_W-1:0] LINK_REG = RA_W'(5'd31);
    localparam logic            FWD_ON   = (EN_FWD != 0);

    // src_a/src_b hold rs/rt only when the instruction reads them, zero otherwise.
    typedef struct packed {
        logic             write;
        logic [RA_W-1:0]  dest;
        logic [ALU_W-1:0] alu_op;
        logic             alu_src;
        logic             mem_read;
        logic             mem_write;
        logic             mem_to_reg;
        logic             link;
        logic             beq;
        logic             bne;
        logic             illegal;
        logic [RA_W-1:0]  src_a;
        logic [RA_W-1:0]  src_b;
    } idex_t;

    typedef struct packed {
        logic            write;
        logic [RA_W-1:0] dest;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
    } exmem_t;

    typedef struct packed {
        logic            write;
        logic [RA_W-1:0] dest;
        logic            mem_to_reg;
    } memwb_t;

    idex_t  dec_s;
    logic   dec_jump_s;
    logic   dec_jr_s;
    idex_t  idex_d, idex_q;
    exmem_t exmem_d, exmem_q;
    memwb_t memwb_d, memwb_q;
    logic   ld_use_s, jr_haz_s, raw_haz_s, raw_stall_s, taken_s;

    function automatic logic [ALU_W-1:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_XOR:  return ALU_XOR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic hit(input logic wr, input logic [RA_W-1:0] dst, input logic [RA_W-1:0] src);
        return wr && (dst != '0) && (dst == src);
    endfunction

    // Decode the ID-stage instruction into a control bundle.
    always_comb begin
        dec_s      = '0;
        dec_jump_s = 1'b0;
        dec_jr_s   = 1'b0;
        case (id_opcode)
            OP_RTYPE: begin
                case (id_func)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT: begin
                        dec_s.write  = 1'b1;
                        dec_s.dest   = id_rd;
                        dec_s.alu_op = rtype_alu(id_func);
                        dec_s.src_a  = id_rs;
                        dec_s.src_b  = id_rt;
                    end
                    FN_JR: begin
                        dec_s.src_a = id_rs;
                        dec_jr_s    = 1'b1;
                    end
                    FN_NOP:  dec_s = '0;
                    default: dec_s.illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                dec_s.write      = 1'b1;
                dec_s.dest       = id_rt;
                dec_s.alu_src    = 1'b1;
                dec_s.mem_read   = 1'b1;
                dec_s.mem_to_reg = 1'b1;
                dec_s.src_a      = id_rs;
            end
            OP_SW: begin
                dec_s.alu_src   = 1'b1;
                dec_s.mem_write = 1'b1;
                dec_s.src_a     = id_rs;
                dec_s.src_b     = id_rt;
            end
            OP_ADDI, OP_SLTI: begin
                dec_s.write   = 1'b1;
                dec_s.dest    = id_rt;
                dec_s.alu_op  = (id_opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                dec_s.alu_src = 1'b1;
                dec_s.src_a   = id_rs;
            end
            OP_BEQ, OP_BNE: begin
                dec_s.alu_op = ALU_SUB;
                dec_s.beq    = (id_opcode == OP_BEQ);
                dec_s.bne    = (id_opcode == OP_BNE);
                dec_s.src_a  = id_rs;
                dec_s.src_b  = id_rt;
            end
            OP_J: dec_jump_s = 1'b1;
            OP_JAL: begin
                dec_s.write = 1'b1;
                dec_s.dest  = LINK_REG;
                dec_s.link  = 1'b1;
                dec_jump_s  = 1'b1;
            end
            default: dec_s.illegal = 1'b1;
        endcase
        dec_s.write = dec_s.write && (dec_s.dest != '0);
    end

    // Hazard detection against the instructions currently in EX and MEM.
    always_comb begin
        taken_s  = (idex_q.beq && ex_zero) || (idex_q.bne && !ex_zero);
        ld_use_s = idex_q.mem_read && (idex_q.dest != '0) &&
                   ((idex_q.dest == dec_s.src_a) || (idex_q.dest == dec_s.src_b));
        jr_haz_s = dec_jr_s && (hit(idex_q.write, idex_q.dest, id_rs) ||
                                hit(exmem_q.write, exmem_q.dest, id_rs));
        raw_haz_s = !FWD_ON &&
                    (hit(idex_q.write, idex_q.dest, dec_s.src_a)   ||
                     hit(idex_q.write, idex_q.dest, dec_s.src_b)   ||
                     hit(exmem_q.write, exmem_q.dest, dec_s.src_a) ||
                     hit(exmem_q.write, exmem_q.dest, dec_s.src_b));
        raw_stall_s = ld_use_s || jr_haz_s || raw_haz_s;
    end

    // PC selection and front-end control; a taken branch overrides any stall.
    always_comb begin
        stall      = 1'b0;
        flush_ifid = 1'b0;
        pc_sel     = PC_SEQ;
        if (!rst_n) begin
            pc_sel = PC_SEQ;
        end else if (taken_s) begin
            pc_sel     = PC_BR;
            flush_ifid = 1'b1;
        end else if (raw_stall_s) begin
            stall = 1'b1;
        end else if (dec_jump_s) begin
            pc_sel     = PC_JMP;
            flush_ifid = 1'b1;
        end else if (dec_jr_s) begin
            pc_sel     = PC_JR;
            flush_ifid = 1'b1;
        end else begin
            pc_sel = PC_SEQ;
        end
    end

    // Operand forwarding: the younger producer in EX/MEM wins over MEM/WB.
    always_comb begin
        fwd_a = 2'd0;
        fwd_b = 2'd0;
        if (FWD_ON && hit(exmem_q.write, exmem_q.dest, idex_q.src_a)) begin
            fwd_a = 2'd1;
        end else if (FWD_ON && hit(memwb_q.write, memwb_q.dest, idex_q.src_a)) begin
            fwd_a = 2'd2;
        end else begin
            fwd_a = 2'd0;
        end
        if (FWD_ON && hit(exmem_q.write, exmem_q.dest, idex_q.src_b)) begin
            fwd_b = 2'd1;
        end else if (FWD_ON && hit(memwb_q.write, memwb_q.dest, idex_q.src_b)) begin
            fwd_b = 2'd2;
        end else begin
            fwd_b = 2'd0;
        end
    end

    // Next-state of the stage registers; stalls and taken branches insert a bubble.
    always_comb begin
        idex_d = dec_s;
        if (taken_s || raw_stall_s) begin
            idex_d = '0;
        end else begin
            idex_d = dec_s;
        end
        exmem_d.write      = idex_q.write;
        exmem_d.dest       = idex_q.dest;
        exmem_d.mem_read   = idex_q.mem_read;
        exmem_d.mem_write  = idex_q.mem_write;
        exmem_d.mem_to_reg = idex_q.mem_to_reg;
        memwb_d.write      = exmem_q.write;
        memwb_d.dest       = exmem_q.dest;
        memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    end

    // Stage registers, cleared to bubbles on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign ex_alu_op     = idex_q.alu_op;
    assign ex_alu_src    = idex_q.alu_src;
    assign ex_link       = idex_q.link;
    assign ex_illegal    = idex_q.illegal;
    assign mem_read      = exmem_q.mem_read;
    assign mem_write     = exmem_q.mem_write;
    assign wb_write      = memwb_q.write;
    assign wb_mem_to_reg = memwb_q.mem_to_reg;
    assign wb_dest       = memwb_q.dest;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: a forwarding and a non-forwarding instance share the ID stream
// and are compared every cycle against an instruction-level pipeline model.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] id_opcode, id_func;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_zero;
    logic [22:0] obs [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        logic [2:0] ex_alu_op;
        logic       ex_alu_src, ex_link, ex_illegal, mem_read, mem_write, wb_write, wb_mem_to_reg;
        logic [4:0] wb_dest;
        logic [1:0] fwd_a, fwd_b, pc_sel;
        logic       stall, flush_ifid;

        pipe_ctrl_unit #(.RA_W(5), .ALU_W(3), .EN_FWD((g == 0) ? 1 : 0)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .id_opcode(id_opcode), .id_func(id_func),
            .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
            .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_link(ex_link), .ex_illegal(ex_illegal),
            .mem_read(mem_read), .mem_write(mem_write),
            .wb_write(wb_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dest(wb_dest),
            .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .flush_ifid(flush_ifid), .pc_sel(pc_sel)
        );

        assign obs[g] = {ex_alu_op, ex_alu_src, ex_link, ex_illegal, mem_read, mem_write,
                         wb_write, wb_mem_to_reg, wb_dest, fwd_a, fwd_b, stall, flush_ifid, pc_sel};
    end

    // Instruction-level model: each stage holds the effects of one named instruction.
    typedef enum int {I_BUB, I_ILL, I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLT, I_JR,
                      I_LW, I_SW, I_ADDI, I_SLTI, I_BEQ, I_BNE, I_J, I_JAL} mn_t;

    typedef struct packed {
        logic       write;
        logic [4:0] dest;
        logic [2:0] alu;
        logic       alu_src, mread, mwrite, m2r, link, illegal, beq, bne;
        logic [4:0] src_a, src_b;
    } rec_t;

    rec_t m_ex [2];
    rec_t m_mem [2];
    rec_t m_wb [2];
    rec_t cur_d;
    mn_t  cur_m;
    logic cur_z;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    logic [5:0] fn_tab [8] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd42, 6'd8, 6'd0};
    logic [5:0] op_tab [8] = '{6'd35, 6'd43, 6'd8, 6'd10, 6'd4, 6'd5, 6'd2, 6'd3};

    function automatic mn_t classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0) begin
            case (fn)
                6'd0:    return I_BUB;
                6'd8:    return I_JR;
                6'd32:   return I_ADD;
                6'd34:   return I_SUB;
                6'd36:   return I_AND;
                6'd37:   return I_OR;
                6'd38:   return I_XOR;
                6'd42:   return I_SLT;
                default: return I_ILL;
            endcase
        end
        case (op)
            6'd2:    return I_J;
            6'd3:    return I_JAL;
            6'd4:    return I_BEQ;
            6'd5:    return I_BNE;
            6'd8:    return I_ADDI;
            6'd10:   return I_SLTI;
            6'd35:   return I_LW;
            6'd43:   return I_SW;
            default: return I_ILL;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input mn_t m);
        case (m)
            I_SUB, I_BEQ, I_BNE: return 3'd1;
            I_AND:               return 3'd2;
            I_OR:                return 3'd3;
            I_SLT, I_SLTI:       return 3'd4;
            I_XOR:               return 3'd5;
            default:             return 3'd0;
        endcase
    endfunction

    function automatic rec_t build(input mn_t m, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        rec_t r = '0;
        case (m)
            I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLT: begin r.dest = rd; r.src_a = rs; r.src_b = rt; end
            I_LW:   begin r.dest = rt; r.src_a = rs; r.alu_src = 1'b1; r.mread = 1'b1; r.m2r = 1'b1; end
            I_SW:   begin r.src_a = rs; r.src_b = rt; r.alu_src = 1'b1; r.mwrite = 1'b1; end
            I_ADDI, I_SLTI: begin r.dest = rt; r.src_a = rs; r.alu_src = 1'b1; end
            I_BEQ, I_BNE: begin r.src_a = rs; r.src_b = rt; r.beq = (m == I_BEQ); r.bne = (m == I_BNE); end
            I_JR:   r.src_a = rs;
            I_JAL:  begin r.dest = 5'd31; r.link = 1'b1; end
            I_ILL:  r.illegal = 1'b1;
            default: r = '0;
        endcase
        r.alu   = alu_of(m);
        r.write = (r.dest != 5'd0);
        return r;
    endfunction

    function automatic logic pending(input rec_t s, input logic [4:0] r);
        return s.write && (s.dest == r);
    endfunction

    // Cfg 0 forwards; cfg 1 waits for every in-flight producer in EX or MEM.
    function automatic logic must_wait(input int c, input rec_t d, input mn_t m);
        logic [4:0] srcs [2];
        logic w = 1'b0;
        srcs[0] = d.src_a;
        srcs[1] = d.src_b;
        for (int i = 0; i < 2; i++) begin
            if (srcs[i] != 5'd0) begin
                if (m_ex[c].mread && m_ex[c].dest == srcs[i]) w = 1'b1;
                if ((c == 1 || m == I_JR) && (pending(m_ex[c], srcs[i]) || pending(m_mem[c], srcs[i]))) w = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [1:0] fwd_of(input int c, input logic [4:0] s);
        if (c == 1 || s == 5'd0) return 2'd0;
        if (pending(m_mem[c], s)) return 2'd1;
        if (pending(m_wb[c], s)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [22:0] expect_obs(input int c, input rec_t d, input mn_t m, input logic z);
        logic taken = (m_ex[c].beq && z) || (m_ex[c].bne && !z);
        logic wt = must_wait(c, d, m);
        logic st = 1'b0;
        logic fl = 1'b0;
        logic [1:0] ps = 2'd0;
        if (taken) begin ps = 2'd1; fl = 1'b1; end
        else if (wt) st = 1'b1;
        else if (m == I_J || m == I_JAL) begin ps = 2'd2; fl = 1'b1; end
        else if (m == I_JR) begin ps = 2'd3; fl = 1'b1; end
        return {m_ex[c].alu, m_ex[c].alu_src, m_ex[c].link, m_ex[c].illegal, m_mem[c].mread, m_mem[c].mwrite,
                m_wb[c].write, m_wb[c].m2r, m_wb[c].dest, fwd_of(c, m_ex[c].src_a), fwd_of(c, m_ex[c].src_b),
                st, fl, ps};
    endfunction

    task automatic chk(input string tag, input int c, input logic [22:0] got, input logic [22:0] want);
        n_total++;
        assert (got === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cfg%0d observed %h expected %h", tag, c, got, want);
        end
    endtask

    task automatic chkf(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_total++;
        assert (got === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic present(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic z, input string tag);
        id_opcode = op; id_func = fn; id_rs = rs; id_rt = rt; id_rd = rd; ex_zero = z;
        cur_m = classify(op, fn);
        cur_d = build(cur_m, rs, rt, rd);
        cur_z = z;
        @(negedge clk);
        #1;
        for (int c = 0; c < 2; c++) chk(tag, c, obs[c], expect_obs(c, cur_d, cur_m, cur_z));
    endtask

    task automatic advance();
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            logic taken = (m_ex[c].beq && cur_z) || (m_ex[c].bne && !cur_z);
            logic wt = must_wait(c, cur_d, cur_m);
            m_wb[c]  = m_mem[c];
            m_mem[c] = m_ex[c];
            m_ex[c]  = (taken || wt) ? '0 : cur_d;
        end
        #1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin m_ex[c] = '0; m_mem[c] = '0; m_wb[c] = '0; end
        cur_d = '0; cur_m = I_BUB; cur_z = 1'b0;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin present(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, "nop"); advance(); end
    endtask

    initial begin
        int k;
        logic [5:0] rop, rfn;
        logic [4:0] rrs, rrt, rrd;
        logic rz;

        rst_n = 1'b0;
        id_opcode = 6'd3; id_func = 6'd0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; ex_zero = 1'b0;
        model_clear();
        #12;
        for (int c = 0; c < 2; c++) chk("reset_jal_in_id", c, obs[c], 23'd0);
        id_opcode = 6'd0;
        @(negedge clk);
        rst_n = 1'b1;
        advance();

        // ADD r3,r1,r2 ; SUB r4,r3,r1 ; AND r5,r3,r4
        present(6'd0, 6'd32, 5'd1, 5'd2, 5'd3, 1'b0, "add"); advance();
        present(6'd0, 6'd34, 5'd3, 5'd1, 5'd4, 1'b0, "sub"); advance();
        present(6'd0, 6'd36, 5'd3, 5'd4, 5'd5, 1'b0, "and");
        chkf("sub_fwd_a", 8'(obs[0][7:6]), 8'd1);
        chkf("sub_alu_op", 8'(obs[0][22:20]), 8'd1);
        advance();
        present(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, "nop");
        chkf("and_fwd_a", 8'(obs[0][7:6]), 8'd2);
        chkf("and_fwd_b", 8'(obs[0][5:4]), 8'd1);
        advance();
        nops(3);

        // LW r5 ; ADD r6,r5,r5 held in ID while it stalls
        present(6'd35, 6'd0, 5'd1, 5'd5, 5'd0, 1'b0, "lw"); advance();
        present(6'd0, 6'd32, 5'd5, 5'd5, 5'd6, 1'b0, "lu_add1");
        chkf("lu_stall1_fwd", 8'(obs[0][3]), 8'd1);
        chkf("lu_stall1_nofwd", 8'(obs[1][3]), 8'd1);
        advance();
        present(6'd0, 6'd32, 5'd5, 5'd5, 5'd6, 1'b0, "lu_add2");
        chkf("lu_stall2_fwd", 8'(obs[0][3]), 8'd0);
        chkf("lu_bubble_ex", 8'(obs[0][22:17]), 8'd0);
        chkf("lu_stall2_nofwd", 8'(obs[1][3]), 8'd1);
        advance();
        present(6'd0, 6'd32, 5'd5, 5'd5, 5'd6, 1'b0, "lu_add3");
        chkf("lu_fwd_a", 8'(obs[0][7:6]), 8'd2);
        chkf("lu_fwd_b", 8'(obs[0][5:4]), 8'd2);
        chkf("lu_stall3_nofwd", 8'(obs[1][3]), 8'd0);
        advance();
        nops(3);

        // BEQ taken squashes the ID instruction; BNE with zero set is not taken
        present(6'd4, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0, "beq"); advance();
        present(6'd0, 6'd32, 5'd1, 5'd2, 5'd8, 1'b1, "beq_shadow");
        chkf("beq_pc_sel", 8'(obs[0][1:0]), 8'd1);
        chkf("beq_flush", 8'(obs[0][2]), 8'd1);
        advance();
        present(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, "nop"); advance();
        present(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, "nop"); advance();
        present(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, "nop");
        chkf("squashed_wb_write", 8'(obs[0][14]), 8'd0);
        advance();
        present(6'd5, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0, "bne"); advance();
        present(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b1, "bne_ex");
        chkf("bne_pc_sel", 8'(obs[0][1:0]), 8'd0);
        advance();

        // JAL
        present(6'd3, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, "jal");
        chkf("jal_pc_sel", 8'(obs[0][1:0]), 8'd2);
        chkf("jal_flush", 8'(obs[0][2]), 8'd1);
        advance();
        present(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, "jal_ex");
        chkf("jal_link", 8'(obs[0][18]), 8'd1);
        chkf("jal_pc_after", 8'(obs[0][1:0]), 8'd0);
        advance();
        present(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, "jal_mem"); advance();
        present(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, "jal_wb");
        chkf("jal_wb_write", 8'(obs[0][14]), 8'd1);
        chkf("jal_wb_dest", 8'(obs[0][12:8]), 8'd31);
        advance();
        nops(2);

        // ADDI r7 ; JR r7 held for two stall cycles
        present(6'd8, 6'd0, 5'd0, 5'd7, 5'd0, 1'b0, "addi"); advance();
        present(6'd0, 6'd8, 5'd7, 5'd0, 5'd0, 1'b0, "jr1");
        chkf("jr_stall1", 8'(obs[0][3]), 8'd1);
        advance();
        present(6'd0, 6'd8, 5'd7, 5'd0, 5'd0, 1'b0, "jr2");
        chkf("jr_stall2", 8'(obs[0][3]), 8'd1);
        advance();
        present(6'd0, 6'd8, 5'd7, 5'd0, 5'd0, 1'b0, "jr3");
        chkf("jr_stall3", 8'(obs[0][3]), 8'd0);
        chkf("jr_pc_sel", 8'(obs[0][1:0]), 8'd3);
        advance();
        nops(3);

        // Illegal opcode, then ADD to r0
        present(6'd63, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0, "illegal"); advance();
        present(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, "illegal_ex");
        chkf("illegal_ex_bits", 8'(obs[0][22:17]), 8'd1);
        chkf("illegal_mem", 8'(obs[0][16:15]), 8'd0);
        advance();
        present(6'd0, 6'd32, 5'd1, 5'd2, 5'd0, 1'b0, "add_r0"); advance();
        nops(2);
        present(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, "add_r0_wb");
        chkf("add_r0_wb_write", 8'(obs[0][14]), 8'd0);
        advance();

        // Asynchronous reset mid-stream
        present(6'd35, 6'd0, 5'd1, 5'd9, 5'd0, 1'b0, "pre_rst_lw"); advance();
        present(6'd3, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, "pre_rst_jal");
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) chk("midreset_all_zero", c, obs[c], 23'd0);
        model_clear();
        id_opcode = 6'd0;
        @(negedge clk);
        rst_n = 1'b1;
        advance();
        present(6'd35, 6'd0, 5'd1, 5'd10, 5'd0, 1'b0, "post_rst_lw"); advance();
        present(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, "post_rst_ex"); advance();
        present(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, "post_rst_mem");
        chkf("post_rst_mem_read", 8'(obs[0][16]), 8'd1);
        advance();

        // Random instruction stream against the model
        for (int i = 0; i < 400; i++) begin
            k = int'($urandom_range(0, 17));
            rrs = 5'($urandom_range(0, 7));
            rrt = 5'($urandom_range(0, 7));
            rrd = 5'($urandom_range(0, 7));
            rz = 1'($urandom_range(0, 1));
            if (k < 8) begin
                rop = 6'd0;
                rfn = fn_tab[k];
            end else if (k < 16) begin
                rop = op_tab[k - 8];
                rfn = 6'($urandom_range(0, 63));
            end else if (k == 16) begin
                rop = ($urandom_range(0, 1) == 0) ? 6'd63 : 6'd1;
                rfn = 6'd0;
            end else begin
                rop = 6'd0;
                rfn = 6'd1;
            end
            present(rop, rfn, rrs, rrt, rrd, rz, "random");
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
